// File: rtl/bsh_32_seq.sv
// Sequential 32-bit shifter (logical/arithmetic/rotate): resolves one shift-amount bit per clock.
// Latency 5 clocks from accept to done; start is ignored while busy, no queueing.
module bsh_32_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] data_in,
    input  logic        dir,
    input  logic [1:0]  mode,
    input  logic [4:0]  sh,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  k;
    logic [31:0] work;
    logic        dir_r;
    logic [1:0]  mode_r;
    logic [4:0]  sh_r;

    logic [4:0]  amt;
    logic [5:0]  ramt;
    logic [31:0] shifted;
    logic [31:0] next_work;

    // Stage k moves the word by 2^k when the matching shift-amount bit is set.
    always_comb begin
        amt       = 5'd1 << k;
        ramt      = 6'd32 - {1'b0, amt};
        shifted   = work;
        next_work = work;
        if (mode_r == 2'b10) begin
            if (dir_r)
                shifted = (work >> amt) | (work << ramt);
            else
                shifted = (work << amt) | (work >> ramt);
        end else if (mode_r == 2'b01 && dir_r) begin
            // The sign bit never changes under arithmetic right shift, so work[31] is the captured bit 31.
            shifted = $unsigned($signed(work) >>> amt);
        end else if (dir_r) begin
            shifted = work >> amt;
        end else begin
            shifted = work << amt;
        end
        if (sh_r[k])
            next_work = shifted;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            k        <= 3'd0;
            work     <= 32'h0;
            dir_r    <= 1'b0;
            mode_r   <= 2'b00;
            sh_r     <= 5'd0;
            done     <= 1'b0;
            data_out <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work   <= data_in;
                        dir_r  <= dir;
                        mode_r <= mode;
                        sh_r   <= sh;
                        k      <= 3'd0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= next_work;
                    if (k == 3'd4) begin
                        k        <= 3'd0;
                        data_out <= next_work;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    k     <= 3'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
